// File: rtl/srl_loader_pkg.sv
// Shared defaults for the srl_loader slice: datapath widths, frame length and
// input buffer depth, plus a counter-width helper.
package srl_loader_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_SRL_DEPTH  = 32;
   localparam int DEF_FIFO_DEPTH = 8;

   // A one-entry depth still needs a 1-bit counter.
   function automatic int cnt_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/srl_loader_if.sv
// Valid/ready stream of packed complex words {imag, real} into srl_loader.
interface srl_loader_if
   import srl_loader_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

   logic                      s_valid;
   logic                      s_ready;
   logic [2*DATA_WIDTH-1:0]   s_data;

   modport master (
      output s_valid,
      output s_data,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data,
      output s_ready
   );

endinterface

// File: rtl/srl_loader_sync_fifo.sv
// Synchronous FIFO with first-word fall-through; one extra pointer bit
// distinguishes full from empty.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/srl_loader.sv
// Feeds the srl delay line: one buffered frame of SRL_DEPTH words, then
// SRL_DEPTH zero flush shifts, flagging the cycles where srl.dout is frame data.
module srl_loader
   import srl_loader_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int SRL_DEPTH  = DEF_SRL_DEPTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst_n,
   srl_loader_if.slave             s_if,
   output logic                    srl_ce,
   output logic [2*DATA_WIDTH-1:0] srl_din,
   output logic                    dout_valid,
   output logic                    frame_done,
   output logic                    busy
);

   localparam int W  = 2*DATA_WIDTH;
   localparam int CW = cnt_width(SRL_DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(SRL_DEPTH-1);
   localparam logic [CW-1:0] CNT_ONE  = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [CW-1:0]  word_cnt;
   logic [CW-1:0]  word_cnt_nxt;
   logic           frame_done_nxt;
   logic           fifo_rd;
   logic [W-1:0]   fifo_dout;
   logic           fifo_full;
   logic           fifo_empty;

   assign s_if.s_ready = !fifo_full;

   sync_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (s_if.s_valid),
      .din   (s_if.s_data),
      .rd_en (fifo_rd),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         word_cnt   <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         word_cnt   <= word_cnt_nxt;
         frame_done <= frame_done_nxt;
      end
   end

   // LOAD stalls on an empty FIFO; FLUSH shifts zeros unconditionally and
   // chains straight into the next frame if words are already waiting.
   always_comb begin
      state_nxt      = state;
      word_cnt_nxt   = word_cnt;
      frame_done_nxt = 1'b0;
      fifo_rd        = 1'b0;
      srl_ce         = 1'b0;
      srl_din        = '0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            srl_ce  = !fifo_empty;
            srl_din = fifo_dout;
            fifo_rd = !fifo_empty;
            if (!fifo_empty) begin
               if (word_cnt == CNT_LAST) begin
                  state_nxt    = FLUSH;
                  word_cnt_nxt = '0;
               end else begin
                  word_cnt_nxt = word_cnt + CNT_ONE;
               end
            end
         end
         FLUSH: begin
            srl_ce = 1'b1;
            if (word_cnt == CNT_LAST) begin
               word_cnt_nxt   = '0;
               frame_done_nxt = 1'b1;
               state_nxt      = fifo_empty ? IDLE : LOAD;
            end else begin
               word_cnt_nxt = word_cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // The whole flush window is exactly the span where srl.dout carries frame words.
   assign dout_valid = (state == FLUSH);
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_srl_loader.sv
// Bench for srl_loader driving a behavioural srl shift register; outputs are
// compared against a frame-level model built from the accepted input words.
module tb_srl_loader;

   localparam int DW = 16;
   localparam int SD = 32;
   localparam int FD = 8;
   localparam int W  = 2*DW;

   logic          clk;
   logic          rst_n;
   logic          srl_ce;
   logic [W-1:0]  srl_din;
   logic          dout_valid;
   logic          frame_done;
   logic          busy;

   int errors = 0;
   int checks = 0;

   srl_loader_if #(.DATA_WIDTH(DW)) sIf ();

   srl_loader #(
      .DATA_WIDTH (DW),
      .SRL_DEPTH  (SD),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_if       (sIf),
      .srl_ce     (srl_ce),
      .srl_din    (srl_din),
      .dout_valid (dout_valid),
      .frame_done (frame_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural srl: SD-stage shift register, never reset.
   logic [W-1:0] srlReg [SD];
   logic [W-1:0] srlDout;
   assign srlDout = srlReg[SD-1];

   always @(posedge clk) begin
      if (srl_ce) begin
         srlReg[0] <= srl_din;
         for (int i = 1; i < SD; i++) begin
            srlReg[i] <= srlReg[i-1];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame-level model: accepted words queue up, the first SD shifts of a
   // frame must carry them in order, then SD zero shifts expose them on dout.
   logic [W-1:0] loadQ[$];
   logic [W-1:0] frameWords[$];
   logic [W-1:0] expWord;
   int  loadCnt = 0;
   int  flushCnt = 0;
   int  frameCnt = 0;
   bit  doneNext = 0;
   bit  expNextValid = 0;
   bit  expNextCe = 0;
   bit  monEn = 0;
   bit  sawNotReady = 0;

   always @(negedge clk) begin
      if (monEn) begin
         checkOutput("s_ready", sIf.s_ready, loadQ.size() < FD);
         checkOutput("frame_done", frame_done, doneNext);
         if (frame_done) frameCnt++;
         doneNext = 0;
         if (expNextValid) begin
            checkOutput("frame_boundary_ce", srl_ce, expNextCe);
            checkOutput("frame_boundary_busy", busy, expNextCe);
            expNextValid = 0;
         end
         checkOutput("dout_valid", dout_valid, loadCnt == SD);
         if (loadCnt == SD) begin
            checkOutput("flush_ce", srl_ce, 1);
            checkOutput("flush_din", srl_din, 0);
            checkOutput("flush_busy", busy, 1);
            checkOutput("srl_dout", srlDout, frameWords[flushCnt]);
            flushCnt++;
            if (flushCnt == SD) begin
               doneNext     = 1;
               expNextValid = 1;
               expNextCe    = (loadQ.size() != 0);
               loadCnt      = 0;
               flushCnt     = 0;
               frameWords.delete();
            end
         end else begin
            if (loadCnt > 0) begin
               checkOutput("load_ce", srl_ce, loadQ.size() != 0);
               checkOutput("load_busy", busy, 1);
            end
            if (srl_ce && loadQ.size() != 0) begin
               expWord = loadQ.pop_front();
               checkOutput("load_din", srl_din, expWord);
               frameWords.push_back(expWord);
               loadCnt++;
            end else if (srl_ce) begin
               checkOutput("ce_without_data", srl_ce, 0);
            end
         end
         if (!sIf.s_ready) sawNotReady = 1;
         if (rst_n && sIf.s_valid && sIf.s_ready) loadQ.push_back(sIf.s_data);
         if (!rst_n) begin
            loadQ.delete();
            frameWords.delete();
            loadCnt      = 0;
            flushCnt     = 0;
            doneNext     = 0;
            expNextValid = 0;
         end
      end
   end

   // Offers one word after 'gap' idle cycles and holds it until accepted.
   task automatic applyStimulus(input logic [W-1:0] word, input int gap);
      bit acc;
      int guard;
      if (gap > 0) begin
         sIf.s_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      sIf.s_valid = 1'b1;
      sIf.s_data  = word;
      acc   = 0;
      guard = 0;
      do begin
         @(negedge clk);
         acc = sIf.s_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!acc && guard < 1000);
      checkOutput("push_accept", acc, 1);
      sIf.s_valid = 1'b0;
   endtask

   task automatic waitFrames(input int target);
      int n = 0;
      while (frameCnt < target && n < 4000) begin
         @(posedge clk);
         n++;
      end
      #1;
      checkOutput("frame_count", frameCnt, target);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ce"}, srl_ce, 0);
      checkOutput({tag, "_din"}, srl_din, 0);
      checkOutput({tag, "_dout_valid"}, dout_valid, 0);
      checkOutput({tag, "_frame_done"}, frame_done, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_s_ready"}, sIf.s_ready, 1);
   endtask

   initial begin
      sIf.s_valid = 1'b0;
      sIf.s_data  = '0;
      rst_n       = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      monEn = 1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle after reset: nothing may move.
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         checkOutput("idle_ce", srl_ce, 0);
         checkOutput("idle_dout_valid", dout_valid, 0);
         checkOutput("idle_busy", busy, 0);
      end
      @(posedge clk);
      #1;

      // Single frame 1..32 back-to-back with cycle-exact expectations.
      fork
         begin
            for (int i = 1; i <= SD; i++) applyStimulus(W'(i), 0);
         end
         begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("latency_idle_ce", srl_ce, 0);
            checkOutput("latency_idle_busy", busy, 0);
            for (int k = 1; k <= SD; k++) begin
               @(negedge clk);
               checkOutput("f1_load_ce", srl_ce, 1);
               checkOutput("f1_load_din", srl_din, k);
            end
            for (int k = 1; k <= SD; k++) begin
               @(negedge clk);
               checkOutput("f1_flush_din", srl_din, 0);
               checkOutput("f1_dout_valid", dout_valid, 1);
               checkOutput("f1_dout", srlDout, k);
            end
            @(negedge clk);
            checkOutput("f1_frame_done", frame_done, 1);
            checkOutput("f1_idle_busy", busy, 0);
         end
      join
      @(posedge clk);
      #1;
      checkOutput("f1_frames", frameCnt, 1);

      // Starved input: s_valid every other cycle.
      for (int i = 1; i <= SD; i++) applyStimulus(W'(i), 1);
      waitFrames(2);

      // Random data with random gaps.
      for (int i = 0; i < SD; i++) applyStimulus(W'($urandom), int'($urandom_range(0, 3)));
      waitFrames(3);

      // Backpressure and back-to-back frames: 96 words with s_valid held high.
      sawNotReady = 0;
      for (int i = 1; i <= 3*SD; i++) applyStimulus(W'(i), 0);
      waitFrames(6);
      checkOutput("backpressure_seen", sawNotReady, 1);

      // Reset in the middle of LOAD, then a fresh frame.
      for (int i = 1; i <= 10; i++) applyStimulus(W'(i), 0);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkResetOutputs("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 101; i <= 100 + SD; i++) applyStimulus(W'(i), 0);
      waitFrames(7);
      repeat (5) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/srl_loader.md
# srl_loader

Upstream feeder for the `srl` delay line in the PE array datapath. Accepts a valid/ready stream of packed complex words (`{imag, real}`, each `DATA_WIDTH` bits) and buffers it in a small FIFO. It then drives `srl` with one frame of `SRL_DEPTH` words, followed by `SRL_DEPTH` zero-filled flush shifts. It reports which cycles of the `srl` output carry frame data, so the downstream PE can consume them directly.

## Interface
Parameters:
- `DATA_WIDTH`, 16 (from `parameters.vh`): width of one real or imag component; word width is `2*DATA_WIDTH`.
- `SRL_DEPTH`, 32: frame length; equals the `srl` shift depth.
- `FIFO_DEPTH`, 8: input buffer entries; power of two, ≥2.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `s_valid` input 1: input word valid.
- `s_ready` output 1: input word accepted when `s_valid & s_ready`.
- `s_data` input `2*DATA_WIDTH`: input word.
- `srl_ce` output 1: shift enable to `srl.ce`.
- `srl_din` output `2*DATA_WIDTH`: data to `srl.din`.
- `dout_valid` output 1: `srl.dout` holds a frame word this cycle.
- `frame_done` output 1: one-cycle pulse after the last frame word leaves `srl`.
- `busy` output 1: FSM is not in IDLE.

## Operation
- Input FIFO:
  - `s_ready = !full`.
  - Push on `s_valid & s_ready`.
  - Pop only in LOAD when `srl_ce` is asserted.
  - Push and pop in the same cycle while full is legal only if the pop frees the slot. `s_ready` is combinational from the registered `full` flag, so there is no same-cycle bypass.
- FSM states: IDLE, LOAD, FLUSH.
  - IDLE: `srl_ce=0`. Go to LOAD when the FIFO is non-empty.
  - LOAD:
    - `srl_ce = !empty`; `srl_din` = FIFO head.
    - `word_cnt` increments on each `srl_ce`.
    - When the count reaches `SRL_DEPTH-1` with `srl_ce` high, go to FLUSH and clear the count.
    - An empty FIFO stalls the shift (`srl_ce=0`, `srl` holds). There is no timeout.
  - FLUSH:
    - `srl_ce=1` every cycle; `srl_din=0`.
    - Runs for exactly `SRL_DEPTH` cycles, counted by `word_cnt`.
    - The FIFO keeps accepting input but is not popped.
    - On the last flush cycle, go to LOAD if the FIFO is non-empty, else go to IDLE.
- `dout_valid` marks the output of frame word k (k = 0..`SRL_DEPTH-1`):
  - After the `SRL_DEPTH`-th load shift, `srl.dout` = word 0.
  - Each flush shift then advances by one word.
  - Therefore `dout_valid` is high from the cycle after the last LOAD shift through the cycle after flush shift `SRL_DEPTH-2`, i.e. `SRL_DEPTH` consecutive cycles.
- `frame_done` is registered and pulses in the cycle after the final flush shift.
- Counters:
  - `word_cnt` is `$clog2(SRL_DEPTH)` bits and wraps only by explicit clear.
  - FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits for full/empty detection.

## Timing
- Reset values (`rst_n=0` at a rising edge):
  - FSM = IDLE; `word_cnt`=0; FIFO emptied.
  - `srl_ce=0`, `srl_din=0`, `dout_valid=0`, `frame_done=0`, `busy=0`.
  - `s_ready=1` from the first cycle after reset release.
- Reset mid-frame: all of the above apply on the next edge. `srl` contents are not cleared; a partial frame is discarded.
- Latency, first word accepted to first `srl_ce` (FIFO previously empty, in IDLE): 2 cycles, covering FIFO write then IDLE→LOAD. From LOAD with an empty FIFO: 1 cycle.
- Frame throughput with no stalls: `2*SRL_DEPTH` cycles per frame, with no idle gap between frames when the FIFO is non-empty.
- `srl_ce`, `srl_din` and `dout_valid` are combinational from registered state and the FIFO head. There is no combinational path from `s_valid` to `srl_ce`.

## Structure
- Add `` `define SRL_DEPTH 32 `` to `parameters.vh` next to `DATA_WIDTH`.
- Localparams for the state encodings (IDLE=2'd0, LOAD=2'd1, FLUSH=2'd2) stay local to the module.
- One sub-module, `sync_fifo` (parameters `WIDTH`, `DEPTH`; ports `clk`, `rst_n`, `wr_en`, `din`, `rd_en`, `dout`, `full`, `empty`), with first-word fall-through on `dout`.
- The bench instantiates `srl_loader` driving a real `srl`.

## Test plan
- Single frame: push words 1..32 back-to-back → 32 consecutive `srl_ce` with `srl_din`=1..32, then 32 cycles of `srl_ce=1` with `din=0`. `srl.dout` = 1..32 exactly on the 32 `dout_valid` cycles, and `frame_done` fires once.
- Starved input: push 1..32 with `s_valid` toggling every other cycle → `srl_ce` gaps match the gaps, and `dout` order is unchanged (1..32).
- Backpressure: hold `s_valid=1` for 3 frames (values 1..96) → `s_ready` drops during FLUSH once 8 words are buffered. All 96 words appear in order, with no loss or duplication.
- Back-to-back frames: FIFO non-empty at the end of FLUSH → the LOAD shift of word 33 follows the last flush cycle with no gap; `busy` stays 1.
- Reset mid-LOAD: assert `rst_n=0` after word 10 → the next cycle shows all outputs at reset values and `s_ready=1`. A fresh frame 101..132 then outputs 101..132.
- Idle: no input for 100 cycles after reset → `srl_ce`, `dout_valid` and `busy` stay 0.
